// File: rtl/mvm_sched_pkg.sv
// Shared types, defaults and configuration check for the
// matrix-vector tile scheduler.
package mvm_sched_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN,
      S_FLUSH,
      S_DONE
   } state_e;

   localparam int K_STEP_DEF   = 16;
   localparam int STAGGER_DEF  = 12;
   localparam int DRAIN_DEF    = 4;

   function automatic logic cfg_legal(
      input int rows,
      input int k,
      input int tile,
      input int max_rows,
      input int k_step,
      input int max_k
   );
      return (rows != 0) && (rows % tile == 0) &&
             (rows <= max_rows) &&
             (k != 0) && (k % k_step == 0) &&
             (k <= max_k);
   endfunction

endpackage

// File: rtl/tile_row_reducer.sv
// Registered row-sum adder tree: one sign-extended sum per tile row,
// one cycle after the tile is presented.
module tile_row_reducer
#(
   parameter int TILE_SIZE = 4,
   parameter int ACC_WIDTH = 32,
   parameter int OUT_WIDTH = 48
)(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        valid_i,
   input  logic signed [ACC_WIDTH-1:0] tile_i [TILE_SIZE][TILE_SIZE],
   output logic                        valid_o,
   output logic signed [OUT_WIDTH-1:0] sum_o [TILE_SIZE]
);

   logic signed [OUT_WIDTH-1:0] sum_d [TILE_SIZE];

   always_comb begin
      for (int i = 0; i < TILE_SIZE; i++) begin
         sum_d[i] = '0;
         for (int j = 0; j < TILE_SIZE; j++) begin
            sum_d[i] = sum_d[i] +
               {{(OUT_WIDTH-ACC_WIDTH){tile_i[i][j][ACC_WIDTH-1]}},
                tile_i[i][j]};
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_o <= 1'b0;
         for (int i = 0; i < TILE_SIZE; i++) sum_o[i] <= '0;
      end else begin
         valid_o <= valid_i;
         if (valid_i) begin
            for (int i = 0; i < TILE_SIZE; i++) sum_o[i] <= sum_d[i];
         end
      end
   end

endmodule

// File: rtl/mvm_tile_scheduler.sv
// Walks A in TILE_SIZE-row blocks: issues staggered k offsets/masks,
// accumulates array-3 row sums, then streams row results out.
module mvm_tile_scheduler
   import mvm_sched_pkg::*;
#(
   parameter int TILE_SIZE    = 4,
   parameter int ACC_WIDTH    = 32,
   parameter int OUT_WIDTH    = 48,
   parameter int MAX_ROWS     = 64,
   parameter int MAX_K        = 1024,
   parameter int K_STEP       = K_STEP_DEF,
   parameter int STAGGER      = STAGGER_DEF,
   parameter int DRAIN_CYCLES = DRAIN_DEF,
   localparam int RW  = $clog2(MAX_ROWS+1),
   localparam int KW  = $clog2(MAX_K+1),
   localparam int BW  = $clog2(MAX_ROWS),
   localparam int KBW = $clog2(MAX_K)+2
)(
   input  logic                        clk,
   input  logic                        rst,
   input  logic [RW-1:0]               cfg_rows,
   input  logic [KW-1:0]               cfg_k,
   input  logic [2:0]                  cfg_mode,
   input  logic                        start,
   output logic                        busy,
   output logic                        done,
   output logic                        cfg_err,
   output logic [2:0]                  dp_mode,
   output logic                        dp_valid_in,
   output logic [BW-1:0]               tile_row_base,
   output logic signed [KBW-1:0]       tile_k_base [TILE_SIZE],
   output logic [TILE_SIZE-1:0]        tile_k_valid,
   input  logic                        dp_valid_out,
   input  logic signed [ACC_WIDTH-1:0] dp_result_3 [TILE_SIZE][TILE_SIZE],
   output logic                        res_valid,
   input  logic                        res_ready,
   output logic [BW-1:0]               res_row,
   output logic signed [OUT_WIDTH-1:0] res_data
);

   localparam int CW = $clog2(DRAIN_CYCLES+1);
   localparam int IW = $clog2(TILE_SIZE);

   state_e                      state_q, state_d;
   logic [KW-1:0]               step_q, step_d, last_step, k_q, k_n;
   logic [CW-1:0]               cnt_q, cnt_d;
   logic [IW-1:0]               row_q, row_d;
   logic [BW-1:0]               base_q, base_d;
   logic [RW-1:0]               rows_q;
   logic [2:0]                  mode_q;
   logic                        err_q, err_d, latch, acc_clr;
   logic signed [KBW-1:0]       kb_q [TILE_SIZE];
   logic signed [KBW-1:0]       kb_d [TILE_SIZE];
   logic [TILE_SIZE-1:0]        kv_q, kv_d;
   int                          kb_n [TILE_SIZE];
   logic signed [OUT_WIDTH-1:0] acc_q [TILE_SIZE];
   logic signed [OUT_WIDTH-1:0] acc_d [TILE_SIZE];
   logic signed [OUT_WIDTH-1:0] red_sum [TILE_SIZE];
   logic                        red_v, cap;

   assign cap = dp_valid_out &&
                (state_q == S_ISSUE || state_q == S_DRAIN);

   tile_row_reducer #(
      .TILE_SIZE (TILE_SIZE),
      .ACC_WIDTH (ACC_WIDTH),
      .OUT_WIDTH (OUT_WIDTH)
   ) u_red (
      .clk     (clk),
      .rst     (rst),
      .valid_i (cap),
      .tile_i  (dp_result_3),
      .valid_o (red_v),
      .sum_o   (red_sum)
   );

   assign last_step = KW'(k_q / K_STEP) + KW'(2);
   assign k_n       = latch ? cfg_k : k_q;

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      cnt_d   = cnt_q;
      row_d   = row_q;
      base_d  = base_q;
      err_d   = 1'b0;
      latch   = 1'b0;
      acc_clr = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               if (cfg_legal(int'(cfg_rows), int'(cfg_k), TILE_SIZE,
                             MAX_ROWS, K_STEP, MAX_K)) begin
                  latch   = 1'b1;
                  acc_clr = 1'b1;
                  base_d  = '0;
                  step_d  = '0;
                  state_d = S_ISSUE;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_ISSUE: begin
            if (step_q == last_step) begin
               cnt_d   = '0;
               state_d = S_DRAIN;
            end else begin
               step_d = step_q + KW'(1);
            end
         end
         S_DRAIN: begin
            if (cnt_q == CW'(DRAIN_CYCLES-1)) begin
               row_d   = '0;
               state_d = S_FLUSH;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_FLUSH: begin
            if (res_valid && res_ready) begin
               if (row_q == IW'(TILE_SIZE-1)) begin
                  if (int'(base_q) + TILE_SIZE >= int'(rows_q)) begin
                     state_d = S_DONE;
                  end else begin
                     base_d  = base_q + BW'(TILE_SIZE);
                     step_d  = '0;
                     acc_clr = 1'b1;
                     state_d = S_ISSUE;
                  end
               end else begin
                  row_d = row_q + IW'(1);
               end
            end
         end
         S_DONE: state_d = S_IDLE;
      endcase
   end

   // Offsets are computed for the coming cycle so they register in step with dp_valid_in.
   always_comb begin
      for (int a = 0; a < TILE_SIZE; a++) begin
         kb_n[a] = int'(step_d) * K_STEP - a * STAGGER;
         kb_d[a] = '0;
         kv_d[a] = 1'b0;
         if (state_d == S_ISSUE) begin
            kb_d[a] = KBW'(kb_n[a]);
            kv_d[a] = (kb_n[a] >= 0) && (kb_n[a] < int'(k_n));
         end
      end
   end

   always_comb begin
      for (int i = 0; i < TILE_SIZE; i++) begin
         acc_d[i] = acc_q[i];
         if (acc_clr) acc_d[i] = '0;
         else if (red_v) acc_d[i] = acc_q[i] + red_sum[i];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         step_q  <= '0;
         cnt_q   <= '0;
         row_q   <= '0;
         base_q  <= '0;
         rows_q  <= '0;
         k_q     <= '0;
         mode_q  <= '0;
         err_q   <= 1'b0;
         kv_q    <= '0;
         for (int i = 0; i < TILE_SIZE; i++) begin
            kb_q[i]  <= '0;
            acc_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         cnt_q   <= cnt_d;
         row_q   <= row_d;
         base_q  <= base_d;
         err_q   <= err_d;
         kv_q    <= kv_d;
         if (latch) begin
            rows_q <= cfg_rows;
            k_q    <= cfg_k;
            mode_q <= cfg_mode;
         end
         for (int i = 0; i < TILE_SIZE; i++) begin
            kb_q[i]  <= kb_d[i];
            acc_q[i] <= acc_d[i];
         end
      end
   end

   assign busy          = (state_q == S_ISSUE) || (state_q == S_DRAIN) ||
                          (state_q == S_FLUSH);
   assign done          = (state_q == S_DONE);
   assign cfg_err       = err_q;
   assign dp_mode       = busy ? mode_q : 3'b000;
   assign dp_valid_in   = (state_q == S_ISSUE);
   assign tile_row_base = base_q;
   assign tile_k_base   = kb_q;
   assign tile_k_valid  = kv_q;
   // A late capture still in the reducer holds off the first row.
   assign res_valid     = (state_q == S_FLUSH) && !red_v;
   assign res_row       = base_q + BW'(row_q);
   assign res_data      = acc_q[row_q];

endmodule

// File: tb/tb_mvm_tile_scheduler.sv
// Directed bench for mvm_tile_scheduler with a small datapath model
// and a golden A*B reference for the full job.
module tb_mvm_tile_scheduler;

   localparam int TS = 4;
   localparam int AW = 32;
   localparam int OW = 48;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [6:0]           cfg_rows;
   logic [10:0]          cfg_k;
   logic [2:0]           cfg_mode;
   logic                 start;
   logic                 busy, done, cfg_err;
   logic [2:0]           dp_mode;
   logic                 dp_valid_in;
   logic [5:0]           tile_row_base;
   logic signed [11:0]   tile_k_base [TS];
   logic [3:0]           tile_k_valid;
   logic                 dp_valid_out;
   logic signed [AW-1:0] dp_result_3 [TS][TS];
   logic                 res_valid, res_ready;
   logic [5:0]           res_row;
   logic signed [OW-1:0] res_data;

   int     compared = 0;
   int     mism     = 0;
   int     A [40][256];
   int     B [256];
   longint gold [64];
   bit     model_en = 1'b0;
   bit     man_v    = 1'b0;
   bit     pend_v   = 1'b0;
   int     pend [TS][TS];
   int     issue_cnt = 0;

   always #5 clk = ~clk;

   mvm_tile_scheduler dut (
      .clk           (clk),
      .rst           (rst),
      .cfg_rows      (cfg_rows),
      .cfg_k         (cfg_k),
      .cfg_mode      (cfg_mode),
      .start         (start),
      .busy          (busy),
      .done          (done),
      .cfg_err       (cfg_err),
      .dp_mode       (dp_mode),
      .dp_valid_in   (dp_valid_in),
      .tile_row_base (tile_row_base),
      .tile_k_base   (tile_k_base),
      .tile_k_valid  (tile_k_valid),
      .dp_valid_out  (dp_valid_out),
      .dp_result_3   (dp_result_3),
      .res_valid     (res_valid),
      .res_ready     (res_ready),
      .res_row       (res_row),
      .res_data      (res_data)
   );

   // Datapath stand-in: one-cycle latency, sums every in-range array chunk.
   always @(negedge clk) begin
      if (dp_valid_in) issue_cnt++;
      if (model_en) begin
         dp_valid_out = pend_v;
         for (int i = 0; i < TS; i++)
            for (int j = 0; j < TS; j++) dp_result_3[i][j] = pend[i][j];
         pend_v = dp_valid_in;
         for (int i = 0; i < TS; i++) begin
            for (int j = 0; j < TS; j++) begin
               pend[i][j] = 0;
               for (int a = 0; a < TS; a++) begin
                  if (tile_k_valid[a]) begin
                     int kk;
                     kk = int'(tile_k_base[a]) + j;
                     pend[i][j] += A[int'(tile_row_base)+i][kk] * B[kk];
                  end
               end
            end
         end
      end else begin
         pend_v       = 1'b0;
         dp_valid_out = man_v;
         for (int i = 0; i < TS; i++)
            for (int j = 0; j < TS; j++) dp_result_3[i][j] = man_v ? 1 : 0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic signed [63:0] obs,
                      input logic signed [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mism++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic collect(input int n, input int stall_at, output int got,
                          output int ndone, output int busy_at_done);
      int                   stall_left;
      bit                   held;
      logic [5:0]           h_row;
      logic signed [OW-1:0] h_data;
      stall_left   = 5;
      held         = 1'b0;
      h_row        = '0;
      h_data       = '0;
      got          = 0;
      ndone        = 0;
      busy_at_done = 0;
      for (int c = 0; c < 3000 && ndone == 0; c++) begin
         if (done) begin
            ndone++;
            busy_at_done = int'(busy);
         end
         if (res_valid && got == stall_at && stall_left > 0) begin
            res_ready = 1'b0;
            if (held) begin
               chk("hold_row", res_row, h_row);
               chk("hold_data", res_data, h_data);
            end
            held       = 1'b1;
            h_row      = res_row;
            h_data     = res_data;
            stall_left--;
         end else begin
            res_ready = 1'b1;
            if (res_valid) begin
               chk("res_row", res_row, got);
               chk("res_data", res_data, (got < n) ? gold[got] : 0);
               got++;
            end
         end
         tick();
      end
      res_ready = 1'b1;
      chk("results_count", got, n);
      chk("done_once", ndone, 1);
      chk("busy_at_done", busy_at_done, 0);
      chk("done_pulse_end", done, 0);
   endtask

   task automatic run_capture(input int stall_at);
      int got, nd, bd;
      chk("busy_before", busy, 0);
      cfg_rows = 7'd4;
      cfg_k    = 11'd16;
      cfg_mode = 3'b000;
      start    = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_rise", busy, 1);
      for (int s = 0; s < 4; s++) begin
         chk("issue_valid", dp_valid_in, 1);
         chk("row_base", tile_row_base, 0);
         for (int a = 0; a < TS; a++)
            chk("k_base", tile_k_base[a], 16*s - 12*a);
         chk("k_mask", tile_k_valid, 64'(1) << s);
         man_v = (s < 3);
         tick();
      end
      chk("drain_no_issue", dp_valid_in, 0);
      for (int r = 0; r < TS; r++) gold[r] = 12;
      collect(4, stall_at, got, nd, bd);
   endtask

   initial begin
      int ic0, got, nd, bd;
      rst       = 1'b1;
      cfg_rows  = '0;
      cfg_k     = '0;
      cfg_mode  = '0;
      start     = 1'b0;
      res_ready = 1'b1;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_valid_in", dp_valid_in, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_kb3", tile_k_base[3], 0);
      tick();
      tick();
      rst = 1'b0;
      tick();

      // offsets, masks and capture with zero-wait results
      run_capture(-1);

      // backpressure on the second row
      run_capture(1);

      // illegal K
      ic0      = issue_cnt;
      cfg_rows = 7'd4;
      cfg_k    = 11'd20;
      start    = 1'b1;
      tick();
      start = 1'b0;
      chk("err_pulse", cfg_err, 1);
      chk("err_busy", busy, 0);
      tick();
      chk("err_clear", cfg_err, 0);
      chk("err_busy2", busy, 0);
      tick();
      tick();
      chk("err_no_issue", issue_cnt - ic0, 0);

      // reset mid-ISSUE
      cfg_rows = 7'd4;
      cfg_k    = 11'd16;
      cfg_mode = 3'b101;
      start    = 1'b1;
      tick();
      start = 1'b0;
      chk("mode_busy", dp_mode, 3'b101);
      man_v = 1'b1;
      tick();
      tick();
      rst = 1'b1;
      #1;
      man_v = 1'b0;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_valid_in", dp_valid_in, 0);
      chk("mid_rst_mask", tile_k_valid, 0);
      chk("mid_rst_kb0", tile_k_base[0], 0);
      chk("mid_rst_mode", dp_mode, 0);
      chk("mid_rst_data", res_data, 0);
      #2;
      rst = 1'b0;
      tick();
      run_capture(-1);

      // full job against golden A*B
      for (int k = 0; k < 256; k++) B[k] = (k % 5) - 2;
      for (int r = 0; r < 40; r++) begin
         gold[r] = 0;
         for (int k = 0; k < 256; k++) begin
            A[r][k] = ((r*3 + k*7) % 11) - 5;
            gold[r] += longint'(A[r][k] * B[k]);
         end
      end
      model_en = 1'b1;
      ic0      = issue_cnt;
      cfg_rows = 7'd40;
      cfg_k    = 11'd256;
      cfg_mode = 3'b010;
      start    = 1'b1;
      tick();
      start = 1'b0;
      chk("full_mode", dp_mode, 3'b010);
      collect(40, -1, got, nd, bd);
      chk("full_issue_cycles", issue_cnt - ic0, 190);
      chk("full_mode_idle", dp_mode, 0);
      model_en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mism);
      $finish;
   end

endmodule
